// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem req/ack fetch, held instruction, LEGv8 next-PC
//
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   imem_req/imem_addr   fetch request and word address (address stable while req is high)
//   imem_ack/imem_rdata  memory response, qualified by imem_req
//   instruction/instr_pc held instruction word and its address
//   instr_valid          held instruction is valid
//   advance              CPU retires the held instruction
//   brtaken/uncondbr     branch decision and offset-format select, sampled on a retire
//   stat_fetched/stat_taken  fetch and taken-branch counters (only with FETCH_STATS_EN)
//
// Optional build macro: FETCH_STATS_EN adds the two 32-bit statistics counters.

module fetch_unit #(
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instruction,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              advance,
    input  logic              brtaken,
    input  logic              uncondbr
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]       stat_fetched,
    output logic [31:0]       stat_taken
`endif
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] next_pc;
    logic [ADDR_W-1:0] off_b;
    logic [ADDR_W-1:0] off_cb;
    logic              fetch_done;
    logic              retire;

    // Branch offsets: word offsets sign-extended to ADDR_W and scaled by 4.
    assign off_b  = {{(ADDR_W-28){instruction[25]}}, instruction[25:0], 2'b00};
    assign off_cb = {{(ADDR_W-21){instruction[23]}}, instruction[23:5], 2'b00};

    always_comb begin
        next_pc = instr_pc + ADDR_W'(4);
        if (brtaken) begin
            next_pc = uncondbr ? (instr_pc + off_b) : (instr_pc + off_cb);
        end
    end

    // An ack only counts while a request is actually out, so acks in HOLD or
    // during reset fall through untouched.
    assign fetch_done  = imem_req && imem_ack;
    assign retire      = (state == HOLD) && advance;
    assign imem_addr   = pc;
    assign instr_valid = (state == HOLD);

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        case (state)
            FETCH: begin
                // Gated on reset so a late ack cannot land while the PC reloads.
                imem_req = !reset;
                if (imem_ack) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (advance) begin
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH;
            pc          <= {RESET_PC[ADDR_W-1:2], 2'b00};
            instruction <= '0;
            instr_pc    <= '0;
        end else begin
            state <= state_nxt;
            if (fetch_done) begin
                instruction <= imem_rdata;
                instr_pc    <= pc;
            end
            if (retire) begin
                pc <= next_pc;
            end
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_fetched <= '0;
            stat_taken   <= '0;
        end else begin
            if (fetch_done) begin
                stat_fetched <= stat_fetched + 32'd1;
            end
            if (retire && brtaken) begin
                stat_taken <= stat_taken + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with a transaction-level reference model

module tb_fetch_unit;

    localparam logic [63:0] RST_PC = 64'h0;
    localparam logic [31:0] NOP    = 32'hD503201F;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [63:0] instr_pc;
    logic        instr_valid;
    logic        advance;
    logic        brtaken;
    logic        uncondbr;
`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched;
    logic [31:0] stat_taken;
`endif

    int checks   = 0;
    int failures = 0;

    fetch_unit #(.ADDR_W(64), .RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instruction (instruction),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .advance     (advance),
        .brtaken     (brtaken),
        .uncondbr    (uncondbr)
`ifdef FETCH_STATS_EN
        ,
        .stat_fetched(stat_fetched),
        .stat_taken  (stat_taken)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding fetch or one held instruction at a time.
    bit          started = 0;
    bit          m_valid = 0;
    logic [63:0] m_pc    = RST_PC & ~64'd3;
    logic [31:0] m_instr = '0;
    logic [63:0] m_ipc   = '0;
    logic [31:0] m_fetched = '0;
    logic [31:0] m_taken   = '0;

    function automatic logic [63:0] model_npc(input logic [63:0] ipc, input logic [31:0] ins,
                                              input logic br, input logic unc);
        logic signed [25:0] imm26;
        logic signed [18:0] imm19;
        longint             off;
        imm26 = ins[25:0];
        imm19 = ins[23:5];
        if (!br)      off = 4;
        else if (unc) off = longint'(imm26) * 4;
        else          off = longint'(imm19) * 4;
        return ipc + off;
    endfunction

    always @(posedge clk) begin
        started = 1;
        if (reset) begin
            m_valid   = 0;
            m_pc      = RST_PC & ~64'd3;
            m_instr   = '0;
            m_ipc     = '0;
            m_fetched = '0;
            m_taken   = '0;
        end else if (!m_valid) begin
            if (imem_ack) begin
                m_instr = imem_rdata;
                m_ipc   = m_pc;
                m_valid = 1;
                m_fetched++;
            end
        end else if (advance) begin
            m_pc = model_npc(m_ipc, m_instr, brtaken, uncondbr);
            if (brtaken) m_taken++;
            m_valid = 0;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("m_req", imem_req, !m_valid && !reset);
            if (!m_valid && !reset) check("m_addr", imem_addr, m_pc);
            check("m_valid", instr_valid, m_valid);
            if (m_valid) begin
                check("m_instr", instruction, m_instr);
                check("m_ipc", instr_pc, m_ipc);
            end
`ifdef FETCH_STATS_EN
            check("m_fetched", stat_fetched, m_fetched);
            check("m_taken", stat_taken, m_taken);
`endif
        end
    end

    // One cycle: inputs applied just after the rising edge, returns at the falling edge.
    task automatic cyc(input logic ack, input logic [31:0] rd, input logic adv,
                       input logic br, input logic unc, input logic rst);
        @(posedge clk);
        #1;
        imem_ack   = ack;
        imem_rdata = rd;
        advance    = adv;
        brtaken    = br;
        uncondbr   = unc;
        reset      = rst;
        @(negedge clk);
    endtask

    // Immediate-ack fetch at an expected address, then retire with the given branch decision.
    task automatic fetch(input logic [63:0] addr, input logic [31:0] ins, input logic br, input logic unc);
        cyc(1'b1, ins, 1'b0, 1'b0, 1'b0, 1'b0);
        check("fetch_req", imem_req, 1'b1);
        check("fetch_addr", imem_addr, addr);
        cyc(1'b0, 32'h0, 1'b1, br, unc, 1'b0);
        check("hold_valid", instr_valid, 1'b1);
        check("hold_pc", instr_pc, addr);
        check("hold_req", imem_req, 1'b0);
    endtask

    initial begin
        reset = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
        advance = 1'b0; brtaken = 1'b0; uncondbr = 1'b0;

        cyc(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("reset_req", imem_req, 1'b0);
        check("reset_valid", instr_valid, 1'b0);

        // B -1 from 0 wraps to the top word, then sequential fetch wraps back to 0.
        fetch(64'h0, 32'h17FFFFFF, 1'b1, 1'b1);
        fetch(64'hFFFF_FFFF_FFFF_FFFC, NOP, 1'b0, 1'b0);

        fetch(64'h0, NOP, 1'b0, 1'b0);
        fetch(64'h4, NOP, 1'b0, 1'b0);
        fetch(64'h8, NOP, 1'b0, 1'b0);
        fetch(64'hC, NOP, 1'b0, 1'b0);
        fetch(64'h10, 32'h17FFFFFE, 1'b1, 1'b1);   // B -2  -> 0x08
        fetch(64'h08, 32'h14000006, 1'b1, 1'b1);   // B +6  -> 0x20
        fetch(64'h20, 32'hB4000060, 1'b1, 1'b0);   // CBZ +3 taken -> 0x2C
        fetch(64'h2C, 32'h17FFFFFD, 1'b1, 1'b1);   // B -3  -> 0x20
        fetch(64'h20, 32'hB4000060, 1'b0, 1'b0);   // CBZ not taken -> 0x24

        // Three-cycle stall at 0x24 with an advance pulse that must be ignored.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 32'h0, (i == 1), 1'b1, 1'b1, 1'b0);
            check("stall_req", imem_req, 1'b1);
            check("stall_addr", imem_addr, 64'h24);
            check("stall_valid", instr_valid, 1'b0);
        end
        cyc(1'b1, 32'h14000007, 1'b0, 1'b0, 1'b0, 1'b0);  // B +7 -> 0x40
        check("stall_ack_addr", imem_addr, 64'h24);

        // Spurious ack in HOLD must not overwrite the held word.
        cyc(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0);
        check("spur_instr", instruction, 32'h14000007);
        check("spur_req", imem_req, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("spur_instr2", instruction, 32'h14000007);
        check("spur_pc", instr_pc, 64'h24);

        // Reset mid-fetch at 0x40 with an ack in the reset cycle.
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("pre_rst_addr", imem_addr, 64'h40);
        check("pre_rst_req", imem_req, 1'b1);
        cyc(1'b1, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0, 1'b1);
        check("rst_req_gate", imem_req, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("post_rst_addr", imem_addr, 64'h0);
        check("post_rst_req", imem_req, 1'b1);
        check("post_rst_valid", instr_valid, 1'b0);
`ifdef FETCH_STATS_EN
        check("post_rst_fetched", stat_fetched, 32'd0);
`endif
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("post_rst_valid2", instr_valid, 1'b0);
        cyc(1'b1, NOP, 1'b0, 1'b0, 1'b0, 1'b0);
        check("refetch_addr", imem_addr, 64'h0);

        // Reset while holding discards the instruction.
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("hold_rst_valid", instr_valid, 1'b1);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("hold_rst_valid2", instr_valid, 1'b0);
        check("hold_rst_addr", imem_addr, 64'h0);

        fetch(64'h0, NOP, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("final_addr", imem_addr, 64'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
